uart_rx_deserializer: RTL and testbench
=======================================

UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 Parameter: data_width, default 8, number of data bits per frame.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rx_in  input  1  serial line, asynchronous to clk, idle high.
REQ-005 prescale  input  6  clk cycles per bit; legal values 8, 16, 32.
REQ-006 par_en  input  1  1 = frame carries a parity bit after the data bits.
REQ-007 par_typ  input  1  parity type: 0 = even, 1 = odd.
REQ-008 p_data  output  data_width  last good received word, LSB received first.
REQ-009 data_valid  output  1  one-cycle pulse; p_data updated with a good frame.
REQ-010 parity_error  output  1  one-cycle pulse; parity mismatch, frame discarded.
REQ-011 stop_error  output  1  one-cycle pulse; stop bit sampled 0, frame discarded.

Function
REQ-012 rx_in SHALL pass through a 2-flop synchronizer reset to 1; all logic below uses the synchronized value (rxs).
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE: rxs==0 -> START, edge_cnt=0, bit_cnt=0, prescale latched into ps_reg.
REQ-015 prescale SHALL be sampled only on the IDLE->START transition; changes mid-frame have no effect.
REQ-016 Illegal prescale values SHALL be latched as 16.
REQ-017 edge_cnt SHALL count 0..ps_reg-1 per bit period and wrap to 0.
REQ-018 Each bit SHALL be the majority vote of rxs at edge_cnt = ps_reg/2-1, ps_reg/2, ps_reg/2+1.
REQ-019 START: at edge_cnt==ps_reg-1, voted bit 0 -> DATA; voted bit 1 -> IDLE (glitch), no output pulse.
REQ-020 DATA: at each bit end, the voted bit SHALL shift into a data_width shift register at the MSB while shifting right, so that the first bit received ends at bit 0.
REQ-021 DATA: after data_width bits -> PARITY if par_en=1, else -> STOP.
REQ-022 PARITY: expected = XOR of data bits (even) or its inverse (odd); mismatch SHALL set an internal par_fail flag.
REQ-023 STOP: at edge_cnt==ps_reg-1 -> IDLE; the outputs are evaluated in the same cycle.
REQ-024 End of STOP, par_fail=1: parity_error SHALL pulse high for exactly the following cycle.
REQ-025 End of STOP, par_fail=0, voted stop=0: stop_error SHALL pulse for exactly the following cycle.
REQ-026 End of STOP, no error: p_data SHALL load the shift register and data_valid SHALL pulse for exactly the following cycle.
REQ-027 Parity error takes priority; at most one of data_valid, parity_error, stop_error SHALL be high in any cycle.
REQ-028 On an error, p_data SHALL hold its previous value.
REQ-029 A start bit arriving immediately after a stop bit SHALL be accepted from IDLE with no lost frame.
REQ-030 par_en and par_typ SHALL be sampled when the FSM leaves DATA.

Reset
REQ-031 rst_n low SHALL immediately force: FSM IDLE, counters 0, synchronizer 1, p_data 0, and data_valid, parity_error, stop_error 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no output pulse; the first falling edge after release starts a fresh frame.

Verification
REQ-033 prescale=8, par_en=0, send 0xA5 -> one data_valid pulse, p_data=0xA5, no error pulses, about 82 cycles after the start edge.
REQ-034 prescale=16, par_en=1, par_typ=0, 0x3C with parity 0 -> data_valid, p_data=0x3C; same byte with parity 1 -> parity_error pulse, p_data stays 0x3C.
REQ-035 prescale=16, 0x81 with stop bit 0 -> stop_error pulse only, p_data unchanged.
REQ-036 prescale=16, rx_in low for 3 cycles then high -> return to IDLE, no pulses; a 1-cycle glitch at a data sample point -> byte still correct.
REQ-037 prescale=32, back-to-back 0x00 then 0xFF with no idle gap -> two data_valid pulses, p_data 0x00 then 0xFF.
REQ-038 rst_n asserted after 4 data bits -> all outputs 0; next frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// UART receiver: 2-flop synchronised line, majority-voted bit sampling,
// optional even/odd parity, and one-cycle result pulses after each frame.
module uart_rx_deserializer #(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [data_width-1:0] p_data,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int BCW = $clog2(data_width) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  function automatic logic [5:0] legal_prescale(input logic [5:0] ps);
    case (ps)
      6'd8, 6'd16, 6'd32: return ps;
      default:            return 6'd16;
    endcase
  endfunction

  function automatic logic expected_parity(input logic [data_width-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic                  rx_meta_q, rxs_q;
  state_t                state_q, state_d;
  logic [5:0]            edge_cnt_q, edge_cnt_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [5:0]            ps_reg_q, ps_reg_d;
  logic [2:0]            votes_q, votes_d;
  logic [data_width-1:0] shift_q, shift_d;
  logic                  par_fail_q, par_fail_d;
  logic                  par_typ_q, par_typ_d;
  logic [data_width-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_error_q, parity_error_d;
  logic                  stop_error_q, stop_error_d;

  logic [5:0]            half_s;
  logic                  bit_end_s;
  logic                  voted_s;

  // Two-flop synchroniser for the asynchronous serial line, idling high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rxs_q     <= rx_meta_q;
    end
  end

  // Frame state, counters, sampling and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      edge_cnt_q     <= 6'd0;
      bit_cnt_q      <= '0;
      ps_reg_q       <= 6'd16;
      votes_q        <= 3'b111;
      shift_q        <= '0;
      par_fail_q     <= 1'b0;
      par_typ_q      <= 1'b0;
      p_data_q       <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      ps_reg_q       <= ps_reg_d;
      votes_q        <= votes_d;
      shift_q        <= shift_d;
      par_fail_q     <= par_fail_d;
      par_typ_q      <= par_typ_d;
      p_data_q       <= p_data_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
    end
  end

  // Next-state logic; the vote is complete well before the bit-end cycle.
  always_comb begin
    state_d        = state_q;
    edge_cnt_d     = edge_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    ps_reg_d       = ps_reg_q;
    votes_d        = votes_q;
    shift_d        = shift_q;
    par_fail_d     = par_fail_q;
    par_typ_d      = par_typ_q;
    p_data_d       = p_data_q;
    data_valid_d   = 1'b0;
    parity_error_d = 1'b0;
    stop_error_d   = 1'b0;

    half_s    = {1'b0, ps_reg_q[5:1]};
    bit_end_s = (edge_cnt_q == (ps_reg_q - 6'd1));
    voted_s   = majority3(votes_q);

    if (state_q != IDLE) begin
      if (bit_end_s) begin
        edge_cnt_d = 6'd0;
      end else begin
        edge_cnt_d = edge_cnt_q + 6'd1;
      end
      if (edge_cnt_q == (half_s - 6'd1)) begin
        votes_d[0] = rxs_q;
      end else if (edge_cnt_q == half_s) begin
        votes_d[1] = rxs_q;
      end else if (edge_cnt_q == (half_s + 6'd1)) begin
        votes_d[2] = rxs_q;
      end else begin
        votes_d = votes_q;
      end
    end else begin
      edge_cnt_d = 6'd0;
    end

    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d    = START;
          edge_cnt_d = 6'd0;
          bit_cnt_d  = '0;
          ps_reg_d   = legal_prescale(prescale);
          par_fail_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          if (voted_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_d = {voted_s, shift_q[data_width-1:1]};
          if (bit_cnt_q == BCW'(data_width - 1)) begin
            par_typ_d = par_typ;
            state_d   = par_en ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          par_fail_d = (voted_s != expected_parity(shift_q, par_typ_q));
          state_d    = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          state_d = IDLE;
          if (par_fail_q) begin
            parity_error_d = 1'b1;
          end else if (!voted_s) begin
            stop_error_d = 1'b1;
          end else begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign p_data       = p_data_q;
  assign data_valid   = data_valid_q;
  assign parity_error = parity_error_q;
  assign stop_error   = stop_error_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomised self-checking bench for uart_rx_deserializer; frame outcomes come
// from a frame-level reference model (data, parity bit, stop bit -> result).
module tb_uart_rx_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rx_in;
  logic [5:0]   prescale;
  logic         par_en;
  logic         par_typ;
  logic [W-1:0] p_data;
  logic         data_valid;
  logic         parity_error;
  logic         stop_error;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int start_cyc = 0;
  logic [W-1:0] last_good = 8'h00;

  // kind: 0 data_valid, 1 parity_error, 2 stop_error, 9 more than one pulse
  typedef struct {
    int       kind;
    logic [W-1:0] data;
    int       cyc;
  } ev_t;
  ev_t evq[$];

  uart_rx_deserializer #(.data_width(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_in        (rx_in),
    .prescale     (prescale),
    .par_en       (par_en),
    .par_typ      (par_typ),
    .p_data       (p_data),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .stop_error   (stop_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Collect every output pulse with the p_data visible in that cycle.
  always @(negedge clk) begin
    int n;
    ev_t e;
    n = int'(data_valid) + int'(parity_error) + int'(stop_error);
    if (rst_n && n > 0) begin
      e.data = p_data;
      e.cyc  = cycle;
      if (n > 1)              e.kind = 9;
      else if (data_valid)    e.kind = 0;
      else if (parity_error)  e.kind = 1;
      else                    e.kind = 2;
      evq.push_back(e);
    end
  end

  function automatic int model_kind(input logic [W-1:0] d, input logic pen,
                                    input logic typ, input logic pbit, input logic sbit);
    if (pen && (pbit != ((^d) ^ typ))) return 1;
    else if (!sbit) return 2;
    else return 0;
  endfunction

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [W-1:0] d, input int ps, input logic [5:0] ps_in,
                            input logic pen, input logic pbit, input logic sbit,
                            input int glitch_idx);
    logic seq[$];
    seq = {};
    seq.push_back(1'b0);
    for (int i = 0; i < W; i++) seq.push_back(d[i]);
    if (pen) seq.push_back(pbit);
    seq.push_back(sbit);
    prescale  = ps_in;
    start_cyc = cycle;
    for (int k = 0; k < seq.size(); k++) begin
      for (int c = 0; c < ps; c++) begin
        if (k == glitch_idx && c == ps / 2) rx_in = ~seq[k];
        else rx_in = seq[k];
        if (k == 0 && c == ps / 2) prescale = 6'($urandom_range(0, 63));
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_event(output ev_t e, output bit got);
    got = 1'b0;
    e.kind = -1; e.data = '0; e.cyc = 0;
    for (int i = 0; i < 80 && evq.size() == 0; i++) @(negedge clk);
    if (evq.size() > 0) begin
      e   = evq.pop_front();
      got = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_in = 1'b1; prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (p_data !== 8'h00) begin
      errors++; $display("FAIL reset_p_data: got %h expected 00", p_data);
    end
    checks++;
    if ({data_valid, parity_error, stop_error} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 000", {data_valid, parity_error, stop_error});
    end
    rst_n = 1'b1;
    idle(20);
  endtask

  task automatic test_basic;
    ev_t e; bit got;
    par_en = 1'b0;
    send_frame(8'hA5, 8, 6'd8, 1'b0, 1'b0, 1'b1, -1);
    wait_event(e, got);
    checks++;
    if (!got || e.kind !== 0 || e.data !== 8'hA5) begin
      errors++; $display("FAIL basic_a5: got kind %0d data %h expected kind 0 data a5", e.kind, e.data);
    end else last_good = 8'hA5;
    checks++;
    if (!got || (e.cyc - start_cyc) < 78 || (e.cyc - start_cyc) > 88) begin
      errors++; $display("FAIL basic_latency: got %0d cycles expected about 82", e.cyc - start_cyc);
    end
    idle(40);
    checks++;
    if (evq.size() != 0) begin
      errors++; $display("FAIL basic_extra: got %0d extra pulses expected 0", evq.size());
      evq.delete();
    end
  endtask

  task automatic test_parity;
    ev_t e; bit got;
    par_en = 1'b1; par_typ = 1'b0;
    send_frame(8'h3C, 16, 6'd16, 1'b1, 1'b0, 1'b1, -1);
    wait_event(e, got);
    checks++;
    if (!got || e.kind !== 0 || e.data !== 8'h3C) begin
      errors++; $display("FAIL parity_good: got kind %0d data %h expected kind 0 data 3c", e.kind, e.data);
    end
    last_good = 8'h3C;
    idle(32);
    send_frame(8'h3C, 16, 6'd16, 1'b1, 1'b1, 1'b1, -1);
    wait_event(e, got);
    checks++;
    if (!got || e.kind !== 1 || e.data !== last_good) begin
      errors++; $display("FAIL parity_bad: got kind %0d data %h expected kind 1 data %h", e.kind, e.data, last_good);
    end
    idle(32);
  endtask

  task automatic test_stop_error;
    ev_t e; bit got;
    par_en = 1'b0;
    send_frame(8'h81, 16, 6'd16, 1'b0, 1'b0, 1'b0, -1);
    wait_event(e, got);
    checks++;
    if (!got || e.kind !== 2 || e.data !== last_good) begin
      errors++; $display("FAIL stop_error: got kind %0d data %h expected kind 2 data %h", e.kind, e.data, last_good);
    end
    idle(48);
  endtask

  task automatic test_glitch;
    ev_t e; bit got;
    par_en = 1'b0; prescale = 6'd16;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    idle(64);
    checks++;
    if (evq.size() != 0) begin
      errors++; $display("FAIL start_glitch: got %0d pulses expected 0", evq.size());
      evq.delete();
    end
    send_frame(8'hB6, 16, 6'd16, 1'b0, 1'b0, 1'b1, 4);
    wait_event(e, got);
    checks++;
    if (!got || e.kind !== 0 || e.data !== 8'hB6) begin
      errors++; $display("FAIL data_glitch: got kind %0d data %h expected kind 0 data b6", e.kind, e.data);
    end else last_good = 8'hB6;
    idle(32);
  endtask

  task automatic test_back_to_back;
    ev_t e; bit got;
    par_en = 1'b0;
    send_frame(8'h00, 32, 6'd32, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'hFF, 32, 6'd32, 1'b0, 1'b0, 1'b1, -1);
    wait_event(e, got);
    checks++;
    if (!got || e.kind !== 0 || e.data !== 8'h00) begin
      errors++; $display("FAIL b2b_first: got kind %0d data %h expected kind 0 data 00", e.kind, e.data);
    end
    wait_event(e, got);
    checks++;
    if (!got || e.kind !== 0 || e.data !== 8'hFF) begin
      errors++; $display("FAIL b2b_second: got kind %0d data %h expected kind 0 data ff", e.kind, e.data);
    end else last_good = 8'hFF;
    idle(64);
  endtask

  task automatic test_illegal_prescale;
    ev_t e; bit got;
    par_en = 1'b0;
    send_frame(8'h69, 16, 6'd12, 1'b0, 1'b0, 1'b1, -1);
    wait_event(e, got);
    checks++;
    if (!got || e.kind !== 0 || e.data !== 8'h69) begin
      errors++; $display("FAIL illegal_prescale: got kind %0d data %h expected kind 0 data 69", e.kind, e.data);
    end else last_good = 8'h69;
    idle(32);
  endtask

  task automatic test_reset_midframe;
    ev_t e; bit got;
    par_en = 1'b0; prescale = 6'd16;
    rx_in = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = i[0];
      repeat (16) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({p_data, data_valid, parity_error, stop_error} !== 11'd0) begin
      errors++; $display("FAIL midframe_reset: got p_data %h pulses %b expected all 0",
                         p_data, {data_valid, parity_error, stop_error});
    end
    last_good = 8'h00;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(200);
    checks++;
    if (evq.size() != 0) begin
      errors++; $display("FAIL midframe_pulse: got %0d pulses expected 0", evq.size());
      evq.delete();
    end
    send_frame(8'h5A, 16, 6'd16, 1'b0, 1'b0, 1'b1, -1);
    wait_event(e, got);
    checks++;
    if (!got || e.kind !== 0 || e.data !== 8'h5A) begin
      errors++; $display("FAIL after_reset: got kind %0d data %h expected kind 0 data 5a", e.kind, e.data);
    end else last_good = 8'h5A;
    idle(32);
  endtask

  task automatic test_random;
    ev_t e; bit got;
    int ps, k;
    logic [W-1:0] d;
    logic pen, typ, pbit, sbit;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 2))
        0:       ps = 8;
        1:       ps = 16;
        default: ps = 32;
      endcase
      d    = W'($urandom);
      pen  = 1'($urandom_range(0, 1));
      typ  = 1'($urandom_range(0, 1));
      pbit = (^d) ^ typ;
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      sbit = ($urandom_range(0, 4) != 0);
      par_en = pen; par_typ = typ;
      k = model_kind(d, pen, typ, pbit, sbit);
      send_frame(d, ps, 6'(ps), pen, pbit, sbit, -1);
      if (k == 0) last_good = d;
      wait_event(e, got);
      checks++;
      if (!got || e.kind !== k || e.data !== last_good) begin
        errors++; $display("FAIL random_%0d: got kind %0d data %h expected kind %0d data %h",
                           n, e.kind, e.data, k, last_good);
      end
      idle(ps * (1 + $urandom_range(0, 2)));
    end
    checks++;
    if (evq.size() != 0) begin
      errors++; $display("FAIL random_extra: got %0d extra pulses expected 0", evq.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_illegal_prescale();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
